mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_prio.sv | 40 ++++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter: bus word types,
// response-tracking state encoding and the starvation-counter width helper.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  be_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_RD_IF = 2'd1;
  localparam arb_state_t ARB_RD_LS = 2'd2;

  // Counter must hold STARVE_LIMIT itself; never narrower than 3 bits.
  function automatic int starve_cnt_width(input int limit);
    int w;
    w = 3;
    while ((1 << w) <= limit) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Priority decision between fetch and load/store: load/store wins unless
// fetch has been refused STARVE_LIMIT consecutive cycles.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ls_req,
  output logic starve,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;

  assign starve = (r_starve_cnt == LIMIT);

  // Grants are qualified by reset so nothing reaches memory while held in reset.
  assign if_gnt = reset & if_req & (~ls_req | starve);
  assign ls_gnt = reset & ls_req & ~if_gnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later readers in the same edge see the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (!starve) r_starve_cnt <= r_starve_cnt + CW'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one unified memory port and routes
// the one-cycle-latency read data back to whichever port issued the load.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic  clk,
  input  logic  reset,

  input  logic  if_req,
  input  addr_t if_addr,
  output logic  if_gnt,
  output logic  if_rvalid,
  output data_t if_rdata,

  input  logic  ls_req,
  input  logic  ls_we,
  input  addr_t ls_addr,
  input  data_t ls_wdata,
  input  be_t   ls_be,
  output logic  ls_gnt,
  output logic  ls_rvalid,
  output data_t ls_rdata,

  output addr_t mem_addr,
  output data_t mem_wdata,
  output logic  mem_we,
  output be_t   mem_be,
  input  data_t mem_rdata
);

  logic       w_if_gnt;
  logic       w_ls_gnt;
  logic       w_starve;
  arb_state_t r_state;
  arb_state_t w_state_nxt;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .ls_req (ls_req),
    .starve (w_starve),
    .if_gnt (w_if_gnt),
    .ls_gnt (w_ls_gnt)
  );

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_gnt;

  // Stores finish at grant, so only reads leave a response pending.
  always_comb begin
    // NOTE: default first so every path assigns -- otherwise a latch is inferred.
    w_state_nxt = ARB_IDLE;
    if (w_if_gnt)                w_state_nxt = ARB_RD_IF;
    else if (w_ls_gnt && !ls_we) w_state_nxt = ARB_RD_LS;
  end

  // NOTE: async reset clears state here, which also kills any in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign if_rvalid = (r_state == ARB_RD_IF);
  assign ls_rvalid = (r_state == ARB_RD_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  // Fetch is always a full-word read; an idle port drives all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
      mem_be   = 4'hF;
    end else if (w_ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_we    = ls_we;
      mem_be    = ls_be;
    end
  end

  a_starve_grants_fetch: assert property (
    @(posedge clk) disable iff (!reset) (w_starve && if_req) |-> w_if_gnt
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic  clk = 1'b0;
  logic  reset;
  logic  if_req;
  addr_t if_addr;
  logic  if_gnt, if_rvalid;
  data_t if_rdata;
  logic  ls_req, ls_we;
  addr_t ls_addr;
  data_t ls_wdata;
  be_t   ls_be;
  logic  ls_gnt, ls_rvalid;
  data_t ls_rdata;
  addr_t mem_addr;
  data_t mem_wdata;
  logic  mem_we;
  be_t   mem_be;
  data_t mem_rdata = '0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory stand-in: returns a hash of the address presented one cycle earlier.
  function automatic data_t data_fn(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always @(posedge clk) mem_rdata <= data_fn(mem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: refused-cycle count and the outstanding read (0 none, 1 fetch, 2 ls).
  int    m_starve;
  int    m_pend;
  addr_t m_pend_addr;
  bit    m_if_g, m_ls_g;

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    ls_be    = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit rst_after_edge = 1'b0);
    bit    sv, ig, lg, ewe;
    addr_t ea;
    data_t ew;
    be_t   eb;
    #1;
    sv  = (m_starve >= LIMIT);
    ig  = reset && if_req && (!ls_req || sv);
    lg  = reset && ls_req && !ig;
    ea  = '0;
    ew  = '0;
    eb  = '0;
    ewe = 1'b0;
    if (ig) begin
      ea = if_addr;
      eb = 4'hF;
    end else if (lg) begin
      ea  = ls_addr;
      ew  = ls_wdata;
      eb  = ls_be;
      ewe = ls_we;
    end
    check("if_gnt",    32'(if_gnt),    32'(ig));
    check("ls_gnt",    32'(ls_gnt),    32'(lg));
    check("mem_addr",  mem_addr,       ea);
    check("mem_wdata", mem_wdata,      ew);
    check("mem_we",    32'(mem_we),    32'(ewe));
    check("mem_be",    32'(mem_be),    32'(eb));
    check("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
    check("if_rdata",  if_rdata,       (m_pend == 1) ? data_fn(m_pend_addr) : 32'h0);
    check("ls_rvalid", 32'(ls_rvalid), 32'(m_pend == 2));
    check("ls_rdata",  ls_rdata,       (m_pend == 2) ? data_fn(m_pend_addr) : 32'h0);
    m_if_g = ig;
    m_ls_g = lg;
    @(posedge clk);
    if (reset) begin
      if (if_req && !ig) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else               m_starve = 0;
      m_pend      = ig ? 1 : ((lg && !ls_we) ? 2 : 0);
      m_pend_addr = ig ? if_addr : ls_addr;
    end else begin
      m_starve = 0;
      m_pend   = 0;
    end
    if (rst_after_edge) begin
      #1;
      reset    = 1'b0;
      m_starve = 0;
      m_pend   = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    m_starve    = 0;
    m_pend      = 0;
    m_pend_addr = '0;
    m_if_g      = 1'b0;
    m_ls_g      = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Reset state, including requests raised while reset is held.
    step();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ls_req = 1'b1; ls_addr = 32'h0000_0080;
    step();
    step();
    idle_inputs();
    reset = 1'b1;
    step();

    // Lone fetch read.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    step();
    idle_inputs();
    step();

    // Store contends with fetch; the store wins and returns nothing.
    if_req = 1'b1; if_addr = 32'h0000_0104;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0200;
    ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF;
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0; ls_be = '0;
    step();
    idle_inputs();
    step();

    // Continuous contention: fetch refused LIMIT times, then granted, then the count restarts.
    if_req = 1'b1; if_addr = 32'h0000_0110;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0210; ls_be = 4'hF;
    repeat (2 * (LIMIT + 1) + 1) step();
    idle_inputs();
    step();

    // Back-to-back alternating reads.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    step();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0400; ls_be = 4'h3;
    step();
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    step();
    idle_inputs();
    step();

    // Reset right after an ls load grant drops the pending response.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0600; ls_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h0000_0604;
    step(1'b1);
    step();
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    if_req = 1'b1; if_addr = 32'h0000_0703;
    step();
    idle_inputs();
    step();

    // Randomized traffic obeying the hold-until-grant rule.
    for (int i = 0; i < 400; i++) begin
      if (!if_req || m_if_g) begin
        if_req  = ($urandom_range(0, 99) < 70);
        if_addr = $urandom;
      end
      if (!ls_req || m_ls_g) begin
        ls_req   = ($urandom_range(0, 99) < 75);
        ls_we    = 1'($urandom_range(0, 1));
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        ls_be    = 4'($urandom_range(0, 15));
      end
      step();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
